cycle_sequencer: RTL and testbench

Instruction-cycle sequencer for the 6502-compatible core. It owns the T-state counter and the opcode register that the `decoder` consumes, and it holds the core on RDY. It also arbitrates RESET, NMI and IRQ at instruction boundaries by forcing a BRK (opcode 8'h00) sequence together with an interrupt kind. It sits between the external bus pins and `decoder`, and advances on the rising edge of `clk_2`.

---
 rtl/cycle_sequencer_if.sv | 30 +++
 rtl/cycle_sequencer.sv | 129 ++++++++++++
 tb/tb_cycle_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_sequencer_if.sv
// Bus bundle between the external pins / decoder and cycle_sequencer.
// master: the side that drives pins and decoder feedback (board, decoder, bench).
// slave : the sequencer itself.
interface cycle_sequencer_if;
  // Inputs to the sequencer
  logic       rdy;
  logic       rw;
  logic [7:0] data_in;
  logic       last_cycle;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  // Outputs from the sequencer
  logic [2:0] t_state;
  logic [7:0] opcode;
  logic       sync;
  logic [1:0] int_kind;
  logic [1:0] vector_sel;
  logic       fault;

  modport master (
    output rdy, rw, data_in, last_cycle, nmi_n, irq_n, i_flag,
    input  t_state, opcode, sync, int_kind, vector_sel, fault
  );

  modport slave (
    input  rdy, rw, data_in, last_cycle, nmi_n, irq_n, i_flag,
    output t_state, opcode, sync, int_kind, vector_sel, fault
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: T-state counter, opcode register, RDY hold,
// and RESET/NMI/IRQ arbitration at instruction boundaries.
// Optional feature: define SEQ_WATCHDOG_EN to turn a T7 overrun into a
// sticky fault plus a forced return to T0.
module cycle_sequencer (
  input  logic             clk_2,
  input  logic             rst,
  cycle_sequencer_if.slave bus
);

  // Advance handshake: a cycle completes when rdy is high or the cycle is a
  // write (rw = 0); writes are never stalled. When the cycle does not
  // complete, every register except the NMI edge detector holds.
  logic       adv;
  logic       eval;
  logic       nmi_edge;

  logic [2:0] t_state_q,  t_state_d;
  logic [7:0] opcode_q,   opcode_d;
  logic [1:0] int_kind_q, int_kind_d;
  logic       nmi_prev_q;
  logic       nmi_latch_q, nmi_latch_d;
`ifdef SEQ_WATCHDOG_EN
  logic       fault_q, fault_d;
`endif

  assign adv      = bus.rdy | ~bus.rw;
  assign eval     = adv & bus.last_cycle;
  assign nmi_edge = nmi_prev_q & ~bus.nmi_n;

  // Next-state for counter, opcode, interrupt kind and NMI latch
  always_comb begin
    t_state_d   = t_state_q;
    opcode_d    = opcode_q;
    int_kind_d  = int_kind_q;
    nmi_latch_d = nmi_latch_q;
`ifdef SEQ_WATCHDOG_EN
    fault_d     = fault_q;
`endif

    if (adv) begin
      if (t_state_q == 3'd0) begin
        // Pending interrupt replaces the fetched opcode with BRK
        opcode_d = (int_kind_q != 2'b00) ? 8'h00 : bus.data_in;
      end

      if (bus.last_cycle) begin
        t_state_d = 3'd0;
      end else if (t_state_q == 3'd0) begin
        t_state_d = 3'd1;
      end else begin
`ifdef SEQ_WATCHDOG_EN
        if (t_state_q == 3'd7) begin
          t_state_d = 3'd0;
          fault_d   = 1'b1;
        end else begin
          t_state_d = t_state_q + 3'd1;
        end
`else
        t_state_d = t_state_q + 3'd1;
`endif
      end
    end

    // Boundary arbitration: NMI over IRQ over none
    if (eval) begin
      if (nmi_latch_q) begin
        int_kind_d  = 2'b01;
        nmi_latch_d = 1'b0;
      end else if (!bus.irq_n && !bus.i_flag) begin
        int_kind_d  = 2'b10;
      end else begin
        int_kind_d  = 2'b00;
      end
    end

    // A fresh NMI edge wins over a same-cycle clear
    if (nmi_edge) begin
      nmi_latch_d = 1'b1;
    end
  end

  // State registers; reset puts the core into the RESET BRK sequence at T1
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      t_state_q   <= 3'd1;
      opcode_q    <= 8'h00;
      int_kind_q  <= 2'b11;
      nmi_prev_q  <= 1'b1;
      nmi_latch_q <= 1'b0;
    end else begin
      t_state_q   <= t_state_d;
      opcode_q    <= opcode_d;
      int_kind_q  <= int_kind_d;
      nmi_prev_q  <= bus.nmi_n;
      nmi_latch_q <= nmi_latch_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  // Vector select for the decoder: NMI->FFFA, RESET->FFFC, IRQ/BRK->FFFE
  always_comb begin
    bus.vector_sel = 2'b11;
    case (int_kind_q)
      2'b01:   bus.vector_sel = 2'b01;
      2'b11:   bus.vector_sel = 2'b10;
      default: bus.vector_sel = 2'b11;
    endcase
  end

  assign bus.t_state  = t_state_q;
  assign bus.opcode   = opcode_q;
  assign bus.int_kind = int_kind_q;
  assign bus.sync     = (t_state_q == 3'd0);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: behavioural model plus per-cycle compare,
// with literal expectations along the directed sequence.
module tb_cycle_sequencer;

  logic clk_2;
  logic rst;
  cycle_sequencer_if bus ();

  cycle_sequencer dut (
    .clk_2 (clk_2),
    .rst   (rst),
    .bus   (bus)
  );

  // Clock / reset block
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  int  checks_total  = 0;
  int  checks_passed = 0;
  bit  running       = 1'b0;

`ifdef SEQ_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_t;
  logic [7:0] m_op;
  int         m_kind;     // 0 none, 1 NMI, 2 IRQ, 3 RESET
  bit         m_fault;
  bit         m_nmi_pend;
  bit         m_nmi_was_high;

  // Vector slot indexed by interrupt kind
  int vec_of_kind [4] = '{3, 1, 3, 2};

  always @(posedge clk_2 or negedge rst) begin : model
    bit go;
    bit fell;
    if (!rst) begin
      m_t = 1; m_op = 8'h00; m_kind = 3; m_fault = 0;
      m_nmi_pend = 0; m_nmi_was_high = 1;
    end else begin
      go   = bus.rdy || !bus.rw;
      fell = m_nmi_was_high && !bus.nmi_n;
      if (go) begin
        if (m_t == 0) m_op = (m_kind == 0) ? bus.data_in : 8'h00;
        if (bus.last_cycle) begin
          m_t = 0;
          if (m_nmi_pend) begin
            m_kind = 1;
            m_nmi_pend = 0;
          end else begin
            m_kind = (!bus.irq_n && !bus.i_flag) ? 2 : 0;
          end
        end else begin
          if (m_t == 7 && WDOG) m_fault = 1;
          m_t = (m_t + 1) % 8;
        end
      end
      if (fell) m_nmi_pend = 1;
      m_nmi_was_high = bus.nmi_n;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_2) begin
    if (running) begin
      check("t_state",    int'(bus.t_state),    m_t);
      check("opcode",     int'(bus.opcode),     int'(m_op));
      check("sync",       int'(bus.sync),       (m_t == 0) ? 1 : 0);
      check("int_kind",   int'(bus.int_kind),   m_kind);
      check("vector_sel", int'(bus.vector_sel), vec_of_kind[m_kind]);
      check("fault",      int'(bus.fault),      int'(m_fault));
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge: apply inputs, let one posedge pass, return at next negedge.
  task automatic drv(input logic last, input logic [7:0] d);
    bus.last_cycle = last;
    bus.data_in    = d;
    @(negedge clk_2);
  endtask

  initial begin
    rst = 1'b0;
    bus.rdy = 1'b1; bus.rw = 1'b1; bus.last_cycle = 1'b0; bus.data_in = 8'h00;
    bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    running = 1'b1;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk_2);
    check("rst_t_state",  int'(bus.t_state), 1);
    check("rst_int_kind", int'(bus.int_kind), 3);
    check("rst_vector",   int'(bus.vector_sel), 2);
    check("rst_sync",     int'(bus.sync), 0);
    check("rst_fault",    int'(bus.fault), 0);
    check("rst_opcode",   int'(bus.opcode), 8'h00);
    #2 rst = 1'b1;

    // RESET BRK sequence T1..T6, last_cycle at T6
    repeat (5) drv(1'b0, 8'h00);
    check("reset_seq_t6",   int'(bus.t_state), 6);
    check("reset_seq_kind", int'(bus.int_kind), 3);
    check("reset_seq_vec",  int'(bus.vector_sel), 2);
    drv(1'b1, 8'h00);
    check("first_t0",      int'(bus.t_state), 0);
    check("first_t0_sync", int'(bus.sync), 1);
    check("first_t0_kind", int'(bus.int_kind), 0);

    // Normal 2-cycle fetch
    drv(1'b0, 8'h69);
    check("fetch_opcode", int'(bus.opcode), 8'h69);
    check("fetch_t1",     int'(bus.t_state), 1);
    drv(1'b1, 8'h00);
    check("fetch_back_t0", int'(bus.t_state), 0);
    check("fetch_kind",    int'(bus.int_kind), 0);

    // RDY stall in T0 (read): everything holds
    bus.rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 8'hAA);
      check("stall_t0",     int'(bus.t_state), 0);
      check("stall_opcode", int'(bus.opcode), 8'h69);
      check("stall_sync",   int'(bus.sync), 1);
    end
    bus.rdy = 1'b1;
    drv(1'b0, 8'h18);
    check("post_stall_opcode", int'(bus.opcode), 8'h18);
    drv(1'b0, 8'h00);
    // Write cycle with rdy low still advances
    bus.rw = 1'b0; bus.rdy = 1'b0;
    drv(1'b0, 8'h00);
    check("write_no_stall_t3", int'(bus.t_state), 3);
    bus.rw = 1'b1; bus.rdy = 1'b1;
    drv(1'b1, 8'h00);

    // NMI edge mid-instruction with IRQ also pending
    drv(1'b0, 8'h4C);
    bus.nmi_n = 1'b0; bus.irq_n = 1'b0; bus.i_flag = 1'b0;
    drv(1'b0, 8'h00);
    drv(1'b1, 8'h00);
    check("nmi_kind", int'(bus.int_kind), 1);
    check("nmi_vec",  int'(bus.vector_sel), 1);
    drv(1'b0, 8'hEA);
    check("nmi_brk_opcode", int'(bus.opcode), 8'h00);
    drv(1'b1, 8'h00);
    check("irq_after_nmi_kind", int'(bus.int_kind), 2);
    check("irq_after_nmi_vec",  int'(bus.vector_sel), 3);
    bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    drv(1'b0, 8'h58);
    check("irq_brk_opcode", int'(bus.opcode), 8'h00);
    drv(1'b1, 8'h00);

    // IRQ masking
    bus.irq_n = 1'b0; bus.i_flag = 1'b1;
    drv(1'b0, 8'hA9);
    drv(1'b1, 8'h00);
    check("irq_masked_kind", int'(bus.int_kind), 0);
    bus.i_flag = 1'b0;
    drv(1'b0, 8'hA2);
    check("masked_fetch_opcode", int'(bus.opcode), 8'hA2);
    drv(1'b1, 8'h00);
    check("irq_taken_kind", int'(bus.int_kind), 2);
    check("irq_taken_vec",  int'(bus.vector_sel), 3);
    // IRQ withdrawn before the boundary is not taken
    bus.irq_n = 1'b1;
    drv(1'b0, 8'hEA);
    bus.irq_n = 1'b0;
    drv(1'b0, 8'h00);
    bus.irq_n = 1'b1;
    drv(1'b1, 8'h00);
    check("irq_withdrawn_kind", int'(bus.int_kind), 0);
    bus.i_flag = 1'b1;

    // Second NMI edge on the clearing cycle: set wins
    drv(1'b0, 8'hEA);
    bus.nmi_n = 1'b0;
    drv(1'b0, 8'h00);
    bus.nmi_n = 1'b1;
    drv(1'b0, 8'h00);
    bus.nmi_n = 1'b0;
    drv(1'b1, 8'h00);
    check("nmi_set_wins_first", int'(bus.int_kind), 1);
    drv(1'b0, 8'hEA);
    bus.nmi_n = 1'b1;
    drv(1'b1, 8'h00);
    check("nmi_set_wins_second", int'(bus.int_kind), 1);
    drv(1'b0, 8'hEA);
    drv(1'b1, 8'h00);
    check("nmi_drained_kind", int'(bus.int_kind), 0);

    // Reset mid-instruction discards a pending NMI
    drv(1'b0, 8'hC8);
    check("pre_reset_opcode", int'(bus.opcode), 8'hC8);
    bus.nmi_n = 1'b0;
    drv(1'b0, 8'h00);
    bus.nmi_n = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk_2);
    check("midrst_t_state",  int'(bus.t_state), 1);
    check("midrst_int_kind", int'(bus.int_kind), 3);
    check("midrst_opcode",   int'(bus.opcode), 8'h00);
    #2 rst = 1'b1;
    drv(1'b0, 8'h00);
    drv(1'b0, 8'h00);
    drv(1'b1, 8'h00);
    check("nmi_discarded_kind", int'(bus.int_kind), 0);

    // T-state overrun: last_cycle never asserted
    drv(1'b0, 8'hE8);
    repeat (6) drv(1'b0, 8'h00);
    check("overrun_t7",    int'(bus.t_state), 7);
    check("overrun_pre_f", int'(bus.fault), 0);
    drv(1'b0, 8'h00);
    check("overrun_t0",    int'(bus.t_state), 0);
    check("overrun_fault", int'(bus.fault), WDOG ? 1 : 0);
    drv(1'b0, 8'hCA);
    check("overrun_refetch", int'(bus.opcode), 8'hCA);
    drv(1'b1, 8'h00);
    check("fault_sticky", int'(bus.fault), WDOG ? 1 : 0);
    #2 rst = 1'b0;
    @(negedge clk_2);
    check("fault_cleared", int'(bus.fault), 0);
    #2 rst = 1'b1;
    drv(1'b0, 8'h00);
    drv(1'b0, 8'h00);

    running = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
